// File: rtl/watchdog_multi_ch.sv
// Multi-channel window watchdog with a key-protected configuration window.
// Each channel reports OK/early/timeout/locked-write events and can request a system reset.
module watchdog_multi_ch #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 16,
    parameter int unsigned RSTW = 8,
    parameter logic [15:0] KEY1 = 16'hAAAA,
    parameter logic [15:0] KEY2 = 16'h5555,
    parameter int unsigned UNLK = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [2:0]       ABUS,
    input  logic [2:0]       SEL,
    input  logic [15:0]      DBUS,
    output logic             RSTOUT,
    output logic [NCH-1:0]   WDFAIL,
    output logic [3*NCH-1:0] FLSTAT,
    output logic             UNLOCKED
);

    localparam int unsigned RCW = $clog2(RSTW + 1);
    localparam int unsigned UCW = $clog2(UNLK + 1);

    localparam logic [2:0] FL_OK     = 3'b001;
    localparam logic [2:0] FL_EARLY  = 3'b010;
    localparam logic [2:0] FL_LOCKED = 3'b011;
    localparam logic [2:0] FL_TOUT   = 3'b100;
    localparam logic [2:0] FL_RESET  = 3'b111;

    typedef enum logic [2:0] {
        A_FRAME = 3'd0,
        A_SERV  = 3'd1,
        A_KICK  = 3'd2,
        A_LIMIT = 3'd3,
        A_EN    = 3'd4,
        A_KEY   = 3'd7
    } addr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLOSED,
        ST_OPEN
    } ch_state_e;

    logic           key1_q, key1_d;
    logic [UCW-1:0] unlk_q, unlk_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [NCH-1:0] req;
    logic [CW-1:0]  wdata;
    logic           key_wr, cfg_wr, unlocked;

    assign wdata    = CW'(DBUS);
    assign key_wr   = WE && (ABUS == A_KEY);
    assign cfg_wr   = WE && ((ABUS == A_FRAME) || (ABUS == A_SERV) ||
                             (ABUS == A_LIMIT) || (ABUS == A_EN));
    assign unlocked = (unlk_q != '0);

    // Any WE that is not the expected key write drops a pending KEY1.
    always_comb begin
        key1_d = key1_q;
        unlk_d = unlk_q;
        if (unlk_q != '0) begin
            unlk_d = unlk_q - UCW'(1);
        end
        if (WE) begin
            if (key_wr && (DBUS == KEY1)) begin
                key1_d = 1'b1;
            end else if (key_wr && (DBUS == KEY2) && key1_q) begin
                key1_d = 1'b0;
                unlk_d = UCW'(UNLK);
            end else begin
                key1_d = 1'b0;
            end
        end
    end

    always_comb begin
        rcnt_d = rcnt_q;
        if (req != '0) begin
            rcnt_d = RCW'(RSTW);
        end else if (rcnt_q != '0) begin
            rcnt_d = rcnt_q - RCW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key1_q <= 1'b0;
            unlk_q <= '0;
            rcnt_q <= '0;
        end else begin
            key1_q <= key1_d;
            unlk_q <= unlk_d;
            rcnt_q <= rcnt_d;
        end
    end

    assign RSTOUT   = (rcnt_q != '0);
    assign UNLOCKED = unlocked;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] frame_q, frame_d, serv_q, serv_d, lim_q, lim_d;
        logic [CW-1:0] cnt_q, cnt_d, fail_q, fail_d, fail_inc, lim_eff;
        logic [2:0]    fl_q, fl_d;
        logic          en_q, en_d, pulse_q, pulse_d, req_c, fail_ev;
        logic          sel_hit, kick;
        ch_state_e     st;

        assign sel_hit  = (SEL == 3'(i));
        assign kick     = WE && (ABUS == A_KICK) && sel_hit;
        assign fail_inc = (fail_q == '1) ? fail_q : fail_q + CW'(1);
        assign lim_eff  = (lim_q == '0) ? CW'(1) : lim_q;

        always_comb begin
            if (!en_q || (frame_q == '0)) begin
                st = ST_IDLE;
            end else if ((serv_q >= frame_q) || (cnt_q >= frame_q - serv_q)) begin
                st = ST_OPEN;
            end else begin
                st = ST_CLOSED;
            end
        end

        always_comb begin
            frame_d = frame_q;
            serv_d  = serv_q;
            lim_d   = lim_q;
            en_d    = en_q;
            cnt_d   = cnt_q;
            fail_d  = fail_q;
            fl_d    = fl_q;
            pulse_d = 1'b0;
            req_c   = 1'b0;
            fail_ev = 1'b0;
            if (cfg_wr && sel_hit) begin
                if (unlocked) begin
                    case (ABUS)
                        A_FRAME: frame_d = wdata;
                        A_SERV:  serv_d  = wdata;
                        A_LIMIT: lim_d   = wdata;
                        default: en_d    = DBUS[0];
                    endcase
                    cnt_d  = '0;
                    fail_d = '0;
                end else begin
                    fl_d = FL_LOCKED;
                end
            end else if (st != ST_IDLE) begin
                // A kick in the last cycle of the frame pre-empts the timeout.
                if (kick) begin
                    cnt_d = '0;
                    if (st == ST_OPEN) begin
                        fl_d = FL_OK;
                    end else begin
                        fl_d    = FL_EARLY;
                        fail_ev = 1'b1;
                    end
                end else if (cnt_q == frame_q - CW'(1)) begin
                    cnt_d   = '0;
                    fl_d    = FL_TOUT;
                    fail_ev = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (fail_ev) begin
                    pulse_d = 1'b1;
                    if (fail_inc >= lim_eff) begin
                        fl_d   = FL_RESET;
                        fail_d = '0;
                        req_c  = 1'b1;
                    end else begin
                        fail_d = fail_inc;
                    end
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                frame_q <= '0;
                serv_q  <= '0;
                lim_q   <= '0;
                en_q    <= 1'b0;
                cnt_q   <= '0;
                fail_q  <= '0;
                fl_q    <= '0;
                pulse_q <= 1'b0;
            end else begin
                frame_q <= frame_d;
                serv_q  <= serv_d;
                lim_q   <= lim_d;
                en_q    <= en_d;
                cnt_q   <= cnt_d;
                fail_q  <= fail_d;
                fl_q    <= fl_d;
                pulse_q <= pulse_d;
            end
        end

        assign req[i]           = req_c;
        assign WDFAIL[i]        = pulse_q;
        assign FLSTAT[3*i +: 3] = fl_q;
    end

endmodule
